multiplexador_arbitrado: RTL and testbench

Parametrised, registered N-channel multiplexer for W-bit words, the next generation of the team's 2:1 8-bit multiplexer. Each input channel offers data through a valid/ready handshake. The block either follows an external select, as the original mux did, or arbitrates round-robin among requesting channels. The chosen word goes into a single output register with its own valid/ready handshake toward the downstream consumer, so the block sits between several producers and one shared datapath.

---
 rtl/multiplexador_arbitrado.sv | 105 ++++++++++
 tb/tb_multiplexador_arbitrado.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multiplexador_arbitrado.sv
// multiplexador_arbitrado: registered N-channel W-bit multiplexer with valid/ready
// on every input channel and on the output. Selection is either a fixed index (p)
// or round-robin among valid channels, chosen by modo.
module multiplexador_arbitrado #(
    parameter int W = 8,
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  a,
    input  logic [N-1:0]    v,
    output logic [N-1:0]    r,
    input  logic [SW-1:0]   p,
    input  logic            modo,
    output logic [W-1:0]    s,
    output logic            sv,
    input  logic            sr,
    output logic [SW-1:0]   sc
);

    logic [SW-1:0] ptr;
    logic [W-1:0]  chan [N];
    logic          livre;
    logic          fix_ok;
    logic          rr_ok;
    logic [SW-1:0] rr_idx;
    logic          grant;
    logic [SW-1:0] g;
    logic          load;

    // Unpack the channel bus into an indexable array.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            chan[i] = a[i*W +: W];
        end
    end

    // Fixed-select grant: only an in-range index whose channel is valid.
    always_comb begin
        fix_ok = 1'b0;
        if (int'(p) < N) begin
            fix_ok = v[p];
        end
    end

    // Round-robin search starting at ptr, wrapping through N-1 back to ptr-1.
    always_comb begin
        int            idx;
        logic [SW-1:0] idx_sw;
        rr_ok  = 1'b0;
        rr_idx = '0;
        idx    = 0;
        idx_sw = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_sw = SW'(idx);
            if (!rr_ok && v[idx_sw]) begin
                rr_ok  = 1'b1;
                rr_idx = idx_sw;
            end
        end
    end

    // Grant selection and the single ready pulse toward the granted producer.
    always_comb begin
        livre = !sv || sr;
        grant = modo ? rr_ok : fix_ok;
        g     = modo ? rr_idx : p;
        load  = livre && grant && rst_n;
        r     = '0;
        // Gated by rst_n so no producer sees ready while the block is held in reset.
        if (load) begin
            r[g] = 1'b1;
        end
    end

    // Output register: load on an input transfer, otherwise empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s  <= '0;
            sv <= 1'b0;
            sc <= '0;
        end else if (load) begin
            s  <= chan[g];
            sc <= g;
            sv <= 1'b1;
        end else if (sr) begin
            sv <= 1'b0;
        end
    end

    // Round-robin pointer moves past the served channel; frozen in fixed mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load && modo) begin
            ptr <= (g == SW'(N - 1)) ? '0 : g + 1'b1;
        end
    end

endmodule

// File: tb/tb_multiplexador_arbitrado.sv
// Directed, table-driven bench for multiplexador_arbitrado (N=4 main instance plus
// an N=3 instance for the out-of-range select case).
module tb_multiplexador_arbitrado;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] a;
    logic [3:0]  v;
    logic [3:0]  r;
    logic [1:0]  p;
    logic        modo;
    logic [7:0]  s;
    logic        sv;
    logic        sr;
    logic [1:0]  sc;

    logic [23:0] a3;
    logic [2:0]  v3;
    logic [2:0]  r3;
    logic [1:0]  p3;
    logic        modo3;
    logic [7:0]  s3;
    logic        sv3;
    logic        sr3;
    logic [1:0]  sc3;

    int checks = 0;
    int errors = 0;

    multiplexador_arbitrado #(.W(8), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .v(v), .r(r), .p(p), .modo(modo),
        .s(s), .sv(sv), .sr(sr), .sc(sc)
    );

    multiplexador_arbitrado #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .a(a3), .v(v3), .r(r3), .p(p3), .modo(modo3),
        .s(s3), .sv(sv3), .sr(sr3), .sc(sc3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       modo;
        logic [1:0] p;
        logic [3:0] v;
        logic       sr;
        logic [3:0] er;
        logic       esv;
        logic [7:0] es;
        logic [1:0] esc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic m, input logic [1:0] pp, input logic [3:0] vv,
                       input logic ss, input logic [3:0] er, input logic esv,
                       input logic [7:0] es, input logic [1:0] esc);
        vec_t t;
        t.modo = m; t.p = pp; t.v = vv; t.sr = ss;
        t.er = er; t.esv = esv; t.es = es; t.esc = esc;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a     = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        a3    = {8'h33, 8'h22, 8'h11};
        v     = 4'b1111;
        p     = 2'd0;
        modo  = 1'b0;
        sr    = 1'b1;
        v3    = 3'b111;
        p3    = 2'd3;
        modo3 = 1'b0;
        sr3   = 1'b1;
        rst_n = 1'b0;

        // Fixed select
        add(0, 2, 4'b1111, 1, 4'b0100, 1, 8'hC2, 2);
        add(0, 2, 4'b1111, 1, 4'b0100, 1, 8'hC2, 2);
        add(0, 1, 4'b1111, 1, 4'b0010, 1, 8'hB1, 1);
        // Round-robin fairness over two rounds
        for (int k = 0; k < 8; k++) begin
            logic [1:0] c;
            logic [7:0] d;
            c = 2'(k % 4);
            d = 8'hA0 + 8'(17 * (k % 4));
            add(1, 0, 4'b1111, 1, 4'b0001 << c, 1, d, c);
        end
        // Sparse valids alternate 1,3
        add(1, 0, 4'b1010, 1, 4'b0010, 1, 8'hB1, 1);
        add(1, 0, 4'b1010, 1, 4'b1000, 1, 8'hD3, 3);
        add(1, 0, 4'b1010, 1, 4'b0010, 1, 8'hB1, 1);
        add(1, 0, 4'b1010, 1, 4'b1000, 1, 8'hD3, 3);
        // Wrap to 0, fixed p=3 twice, resume round-robin from retained ptr=1
        add(1, 0, 4'b1001, 1, 4'b0001, 1, 8'hA0, 0);
        add(0, 3, 4'b1111, 1, 4'b1000, 1, 8'hD3, 3);
        add(0, 3, 4'b1111, 1, 4'b1000, 1, 8'hD3, 3);
        add(1, 3, 4'b1111, 1, 4'b0010, 1, 8'hB1, 1);
        // Backpressure: held word stable, no readies
        for (int k = 0; k < 5; k++) begin
            add(1, 3, 4'b1111, 0, 4'b0000, 1, 8'hB1, 1);
        end
        // Drain and refill in one cycle
        add(1, 3, 4'b1111, 1, 4'b0100, 1, 8'hC2, 2);
        // Drain to empty, then idle
        add(1, 3, 4'b0000, 1, 4'b0000, 0, 8'hC2, 2);
        add(1, 3, 4'b0000, 0, 4'b0000, 0, 8'hC2, 2);
        // Empty slot accepts even with sr=0
        add(0, 0, 4'b0001, 0, 4'b0001, 1, 8'hA0, 0);
        add(0, 0, 4'b0000, 0, 4'b0000, 1, 8'hA0, 0);

        // Reset values while held in reset with every channel valid
        #3;
        check("rst_s", 32'(s), 0);
        check("rst_sv", 32'(sv), 0);
        check("rst_sc", 32'(sc), 0);
        check("rst_r", 32'(r), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            modo = tbl[i].modo;
            p    = tbl[i].p;
            v    = tbl[i].v;
            sr   = tbl[i].sr;
            #1;
            check($sformatf("r[%0d]", i), 32'(r), 32'(tbl[i].er));
            check($sformatf("r3[%0d]", i), 32'(r3), 0);
            step();
            check($sformatf("sv[%0d]", i), 32'(sv), 32'(tbl[i].esv));
            check($sformatf("s[%0d]", i), 32'(s), 32'(tbl[i].es));
            check($sformatf("sc[%0d]", i), 32'(sc), 32'(tbl[i].esc));
            check($sformatf("sv3[%0d]", i), 32'(sv3), 0);
        end

        // Mid-operation reset with a held word and a nonzero pointer
        modo = 1'b1;
        v    = 4'b1111;
        sr   = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_s", 32'(s), 0);
        check("midrst_sv", 32'(sv), 0);
        check("midrst_sc", 32'(sc), 0);
        check("midrst_r", 32'(r), 0);
        @(negedge clk);
        v     = 4'b0000;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("idle_sv", 32'(sv), 0);
            check("idle_r", 32'(r), 0);
        end
        // First grant after reset starts at channel 0
        v  = 4'b1111;
        sr = 1'b1;
        #1;
        check("post_rst_r", 32'(r), 32'h1);
        step();
        check("post_rst_sc", 32'(sc), 0);
        check("post_rst_s", 32'(s), 32'hA0);

        // N=3 in-range select still works
        p3 = 2'd2;
        #1;
        check("n3_r", 32'(r3), 32'h4);
        step();
        check("n3_sv", 32'(sv3), 1);
        check("n3_s", 32'(s3), 32'h33);
        check("n3_sc", 32'(sc3), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
